// File: rtl/ips2l_ddr_rst_pkg.sv
// ips2l_ddr_rst_pkg: shared types and defaults for the DDR3 reset-release sequencer.
//   rst_state_e            : sequencer state encoding
//   DEF_*                  : default filter / gap / timeout settings
//   TO_CNT_WIDTH           : width of the optional lock-timeout counter
package ips2l_ddr_rst_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      PHY_REL   = 2'd1,
      CTRL_REL  = 2'd2,
      DONE      = 2'd3
   } rst_state_e;

   localparam int unsigned DEF_LOCK_FILTER_CYCLES  = 16;
   localparam int unsigned DEF_STAGE_GAP_CYCLES    = 8;
   localparam int unsigned DEF_CNT_WIDTH           = 8;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 4096;
   localparam int unsigned TO_CNT_WIDTH            = 16;

endpackage

// File: rtl/ips2l_ddr_rst_stage_cnt.sv
// ips2l_ddr_rst_stage_cnt: clear/load/increment counter with terminal-count compare.
//   clk, rst_n  : clock, async active-low reset
//   i_clr       : clear to 0 (highest priority)
//   i_load      : load i_load_val
//   i_inc       : increment by one
//   i_tc        : terminal-count value
//   o_tc_c      : combinational flag, counter equals i_tc
module ips2l_ddr_rst_stage_cnt #(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_clr,
   input  logic                 i_load,
   input  logic [CNT_WIDTH-1:0] i_load_val,
   input  logic                 i_inc,
   input  logic [CNT_WIDTH-1:0] i_tc,
   output logic                 o_tc_c
);

   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
   end

   assign o_tc_c = (r_cnt == i_tc);

endmodule

// File: rtl/ips2l_ddr_rst_sync.sv
// ips2l_ddr_rst_sync: two-flop synchronizer, resets to 0.
//   clk, rst_n : clock, async active-low reset
//   i_d        : asynchronous input
//   o_q        : synchronized output (2-edge latency)
module ips2l_ddr_rst_sync #(
   parameter int unsigned DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] i_d,
   output logic [DATA_WIDTH-1:0] o_q
);

   logic [DATA_WIDTH-1:0] r_meta;
   logic [DATA_WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/ips2l_ddr_rst_seq_v1_0.sv
// ips2l_ddr_rst_seq_v1_0: staged reset-release sequencer for the DDR3 IP.
// Filters PLL lock, then releases PHY, controller and user resets in order with
// fixed gaps. Loss of lock or a soft reset request collapses all resets at once.
//   clk, rst_n    : clock, async active-low reset
//   pll_lock      : async PLL lock
//   soft_rst_req  : async level request to re-run the sequence
//   phy_rst_n     : PHY reset (active low, registered)
//   ctrl_rst_n    : controller reset (active low, registered)
//   user_rst_n    : user reset (active low, registered)
//   rst_done      : all resets released (registered)
//   lock_timeout  : sticky lock-wait timeout, only with IPS2L_DDR_RST_SEQ_TIMEOUT_EN
module ips2l_ddr_rst_seq_v1_0
   import ips2l_ddr_rst_pkg::*;
#(
   parameter int unsigned LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
   parameter int unsigned STAGE_GAP_CYCLES    = DEF_STAGE_GAP_CYCLES,
   parameter int unsigned CNT_WIDTH           = DEF_CNT_WIDTH
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
   , parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_lock,
   input  logic soft_rst_req,
   output logic phy_rst_n,
   output logic ctrl_rst_n,
   output logic user_rst_n,
   output logic rst_done
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
   , output logic lock_timeout
`endif
);

   rst_state_e           r_state;
   rst_state_e           w_state_nxt;
   logic                 w_lock_s;
   logic                 w_req_s;
   logic                 w_abort;
   logic                 w_cnt_clr;
   logic                 w_cnt_inc;
   logic                 w_tc_c;
   logic [CNT_WIDTH-1:0] w_tc_val;
   logic                 r_phy_rst_n;
   logic                 r_ctrl_rst_n;
   logic                 r_user_rst_n;
   logic                 r_rst_done;

   // Input synchronizers
   ips2l_ddr_rst_sync #(.DATA_WIDTH(1)) u_sync_lock (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (pll_lock),
      .o_q   (w_lock_s)
   );

   ips2l_ddr_rst_sync #(.DATA_WIDTH(1)) u_sync_req (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (soft_rst_req),
      .o_q   (w_req_s)
   );

   // Shared filter/gap counter
   ips2l_ddr_rst_stage_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_stage_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_cnt_clr),
      .i_load     (1'b0),
      .i_load_val ('0),
      .i_inc      (w_cnt_inc),
      .i_tc       (w_tc_val),
      .o_tc_c     (w_tc_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_LOCK;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and counter control; abort overrides every transition
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_abort     = !w_lock_s || w_req_s;
      w_tc_val    = CNT_WIDTH'(STAGE_GAP_CYCLES - 1);
      if (r_state == WAIT_LOCK) begin
         w_tc_val = CNT_WIDTH'(LOCK_FILTER_CYCLES - 1);
      end
      if (w_abort) begin
         w_state_nxt = WAIT_LOCK;
         w_cnt_clr   = 1'b1;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               if (w_tc_c) begin
                  w_state_nxt = PHY_REL;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
            PHY_REL: begin
               if (w_tc_c) begin
                  w_state_nxt = CTRL_REL;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
            CTRL_REL: begin
               if (w_tc_c) begin
                  w_state_nxt = DONE;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
            default: begin
               w_state_nxt = DONE;
            end
         endcase
      end
   end

   // Registered outputs follow the state being entered, so each release lands on the transition edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phy_rst_n  <= 1'b0;
         r_ctrl_rst_n <= 1'b0;
         r_user_rst_n <= 1'b0;
         r_rst_done   <= 1'b0;
      end else begin
         r_phy_rst_n  <= (w_state_nxt != WAIT_LOCK);
         r_ctrl_rst_n <= (w_state_nxt == CTRL_REL) || (w_state_nxt == DONE);
         r_user_rst_n <= (w_state_nxt == DONE);
         r_rst_done   <= (w_state_nxt == DONE);
      end
   end

   assign phy_rst_n  = r_phy_rst_n;
   assign ctrl_rst_n = r_ctrl_rst_n;
   assign user_rst_n = r_user_rst_n;
   assign rst_done   = r_rst_done;

`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
   logic [TO_CNT_WIDTH-1:0] r_to_cnt;
   logic                    r_lock_timeout;

   // Lock-wait timeout: counts WAIT_LOCK cycles without a request, saturates, sticky flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt       <= '0;
         r_lock_timeout <= 1'b0;
      end else begin
         if (w_state_nxt != WAIT_LOCK) begin
            r_to_cnt <= '0;
         end else if ((r_state == WAIT_LOCK) && !w_req_s &&
                      (r_to_cnt != TO_CNT_WIDTH'(LOCK_TIMEOUT_CYCLES))) begin
            r_to_cnt <= r_to_cnt + TO_CNT_WIDTH'(1);
            if (r_to_cnt == TO_CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1)) begin
               r_lock_timeout <= 1'b1;
            end
         end
         if ((w_state_nxt == DONE) && (r_state != DONE)) begin
            r_lock_timeout <= 1'b0;
         end
      end
   end

   assign lock_timeout = r_lock_timeout;
`endif

endmodule

// File: tb/tb_ips2l_ddr_rst_seq_v1_0.sv
// Bench for ips2l_ddr_rst_seq_v1_0: two instances (default and minimum filter/gap)
// share the inputs and are compared each cycle against a run-length reference model.
module tb_ips2l_ddr_rst_seq_v1_0;

   localparam int unsigned LFC   = 16;
   localparam int unsigned GAP   = 8;
   localparam int unsigned LFC_B = 1;
   localparam int unsigned GAP_B = 1;
   localparam int unsigned NONE  = 999;
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
   localparam int unsigned LTC   = 100;
`endif

   logic clk;
   logic rst_n;
   logic pll_lock;
   logic soft_rst_req;
   logic a_phy, a_ctrl, a_user, a_done;
   logic b_phy, b_ctrl, b_user, b_done;
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
   logic a_to, b_to;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model: consecutive good (lock_s && !req_s) edges since the last abort
   int unsigned m_good = 0;
   logic m_l1 = 1'b0, m_l2 = 1'b0, m_r1 = 1'b0, m_r2 = 1'b0;
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
   int unsigned m_to_cnt = 0;
   logic        m_to     = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ips2l_ddr_rst_seq_v1_0 #(
      .LOCK_FILTER_CYCLES (LFC),
      .STAGE_GAP_CYCLES   (GAP),
      .CNT_WIDTH          (8)
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
      , .LOCK_TIMEOUT_CYCLES (LTC)
`endif
   ) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_lock     (pll_lock),
      .soft_rst_req (soft_rst_req),
      .phy_rst_n    (a_phy),
      .ctrl_rst_n   (a_ctrl),
      .user_rst_n   (a_user),
      .rst_done     (a_done)
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
      , .lock_timeout (a_to)
`endif
   );

   ips2l_ddr_rst_seq_v1_0 #(
      .LOCK_FILTER_CYCLES (LFC_B),
      .STAGE_GAP_CYCLES   (GAP_B),
      .CNT_WIDTH          (8)
   ) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_lock     (pll_lock),
      .soft_rst_req (soft_rst_req),
      .phy_rst_n    (b_phy),
      .ctrl_rst_n   (b_ctrl),
      .user_rst_n   (b_user),
      .rst_done     (b_done)
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
      , .lock_timeout (b_to)
`endif
   );

   function automatic logic [3:0] exp_outs(input int unsigned g, input int unsigned lfc,
                                           input int unsigned gap);
      logic [3:0] v;
      v[3] = (g >= lfc);
      v[2] = (g >= lfc + gap);
      v[1] = (g >= lfc + 2 * gap);
      v[0] = (g >= lfc + 2 * gap);
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge: advance model, then compare both instances
   task automatic step();
      int unsigned old_good;
      @(posedge clk);
      old_good = m_good;
      if (!m_l2 || m_r2) m_good = 0;
      else if (m_good < 10000) m_good++;
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
      if (m_good >= LFC) m_to_cnt = 0;
      else if (old_good < LFC && !m_r2 && m_to_cnt < LTC) begin
         m_to_cnt++;
         if (m_to_cnt == LTC) m_to = 1'b1;
      end
      if (m_good == LFC + 2 * GAP) m_to = 1'b0;
`endif
      m_l2 = m_l1;
      m_r2 = m_r1;
      m_l1 = pll_lock;
      m_r1 = soft_rst_req;
      #1;
      check("a_outs", {28'd0, a_phy, a_ctrl, a_user, a_done}, {28'd0, exp_outs(m_good, LFC, GAP)});
      check("b_outs", {28'd0, b_phy, b_ctrl, b_user, b_done}, {28'd0, exp_outs(m_good, LFC_B, GAP_B)});
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
      check("a_lock_timeout", {31'd0, a_to}, {31'd0, m_to});
`endif
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset pulse between edges; outputs must drop without a clock
   task automatic rst_pulse();
      rst_n = 1'b0;
      #2;
      check("async_rst_a", {28'd0, a_phy, a_ctrl, a_user, a_done}, 32'd0);
      check("async_rst_b", {28'd0, b_phy, b_ctrl, b_user, b_done}, 32'd0);
      m_good = 0;
      m_l1 = 1'b0; m_l2 = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0;
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
      check("async_rst_to", {31'd0, a_to}, 32'd0);
      m_to_cnt = 0;
      m_to     = 1'b0;
`endif
      #1;
      rst_n = 1'b1;
   endtask

   // Run with current inputs held, recording the first edge each output is high
   task automatic run_seq(output int unsigned kp, output int unsigned kc, output int unsigned kd);
      kp = NONE; kc = NONE; kd = NONE;
      for (int k = 0; k < 50; k++) begin
         step();
         if (a_phy  && kp == NONE) kp = k;
         if (a_ctrl && kc == NONE) kc = k;
         if (a_done && kd == NONE) kd = k;
      end
   endtask

   task automatic check_seq(input string tag);
      int unsigned kp, kc, kd;
      run_seq(kp, kc, kd);
      check({tag, "_phy_edge"},  kp, LFC + 1);
      check({tag, "_ctrl_edge"}, kc, LFC + 1 + GAP);
      check({tag, "_done_edge"}, kd, LFC + 1 + 2 * GAP);
   endtask

   initial begin
      int unsigned fall_k;
      logic        prev_phy;
      logic        ctrl_seen;
      int          lo_left;

      rst_n        = 1'b0;
      pll_lock     = 1'b0;
      soft_rst_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", {28'd0, a_phy, a_ctrl, a_user, a_done}, 32'd0);
      check("reset_b", {28'd0, b_phy, b_ctrl, b_user, b_done}, 32'd0);
      rst_n = 1'b1;

      // Hold lock low long enough to cover the lock-wait timeout
      for (int i = 0; i < 110; i++) begin
         step();
`ifdef IPS2L_DDR_RST_SEQ_TIMEOUT_EN
         if (i == LTC - 2) check("timeout_before", {31'd0, a_to}, 32'd0);
         if (i == LTC - 1) check("timeout_at",     {31'd0, a_to}, 32'd1);
`endif
      end

      // Default latency from first sampled-high lock
      pll_lock = 1'b1;
      check_seq("t1");

      // Single-cycle lock glitch mid-filter restarts the filter
      pll_lock = 1'b0;
      steps(3);
      pll_lock = 1'b1;
      steps(10);
      pll_lock = 1'b0;
      step();
      check("glitch_hold", {31'd0, a_phy}, 32'd0);
      pll_lock = 1'b1;
      check_seq("t2");

      // Soft reset request from DONE: outputs fall on the third edge
      soft_rst_req = 1'b1;
      steps(2);
      check("req_e2_done", {31'd0, a_done}, 32'd1);
      step();
      check("req_e3_outs", {28'd0, a_phy, a_ctrl, a_user, a_done}, 32'd0);
      steps(2);
      soft_rst_req = 1'b0;
      check_seq("t3");

      // Lock lost during PHY_REL
      pll_lock = 1'b0;
      steps(3);
      fall_k    = NONE;
      prev_phy  = 1'b0;
      ctrl_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         pll_lock = (k < 20);
         step();
         if (prev_phy && !a_phy && fall_k == NONE) fall_k = k;
         if (a_ctrl) ctrl_seen = 1'b1;
         prev_phy = a_phy;
      end
      check("t4_phy_fall_edge", fall_k, 22);
      check("t4_ctrl_seen", {31'd0, ctrl_seen}, 32'd0);

      // Async reset during CTRL_REL, then a clean restart
      pll_lock = 1'b1;
      steps(30);
      check("t5_in_ctrl_rel", {28'd0, a_phy, a_ctrl, a_user, a_done}, 32'hC);
      rst_pulse();
      check_seq("t5");

      // Randomized lock glitches, soft requests and occasional async resets
      lo_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (lo_left > 0) begin
            pll_lock = 1'b0;
            lo_left--;
         end else if ($urandom_range(0, 149) == 0) begin
            pll_lock = 1'b0;
            lo_left  = int'($urandom_range(0, 3));
         end else begin
            pll_lock = 1'b1;
         end
         soft_rst_req = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 999) == 0) rst_pulse();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
